// File: rtl/snake_mover.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : snake_mover                                                     |
// | Purpose  : Sole initiator on the play-area cell RAM. Each accepted step    |
// |            reads the target cell (1-cycle RAM latency), decides between    |
// |            collision, food and a plain move, writes the new head and       |
// |            erases the old tail. Body coordinates live in an internal ring. |
// | Ports    : clk, reset (sync, active-high)                                  |
// |            step, dir            - move request and direction (0 up,        |
// |                                   1 right, 2 down, 3 left)                 |
// |            area_x/y/we/wdata    - RAM address / write port                 |
// |            area_rdata           - RAM registered read data                 |
// |            busy, dead, length, ate - status                                |
// | Config   : SNAKE_WRAP_EN - when defined, heads leaving the play area wrap  |
// |            to the opposite edge instead of killing the snake.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module snake_mover #(
  parameter int WIDTH      = 80,
  parameter int HEIGHT     = 60,
  parameter int BIT_DEPTH  = 3,
  parameter int MAX_LEN    = 64,
  parameter int START_X    = 40,
  parameter int START_Y    = 30,
  parameter int CELL_EMPTY = 0,
  parameter int CELL_SNAKE = 1,
  parameter int CELL_FOOD  = 2,
  parameter int CELL_WALL  = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           step,
  input  logic [1:0]                     dir,
  output logic [$clog2(WIDTH)-1:0]       area_x,
  output logic [$clog2(HEIGHT)-1:0]      area_y,
  output logic                           area_we,
  output logic [BIT_DEPTH-1:0]           area_wdata,
  input  logic [BIT_DEPTH-1:0]           area_rdata,
  output logic                           busy,
  output logic                           dead,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           ate
);

  localparam int c_xw = $clog2(WIDTH);
  localparam int c_yw = $clog2(HEIGHT);
  localparam int c_lw = $clog2(MAX_LEN+1);
  localparam int c_pw = $clog2(MAX_LEN);

  localparam logic [c_xw:0]          c_width_ext  = (c_xw+1)'(WIDTH);
  localparam logic [c_yw:0]          c_height_ext = (c_yw+1)'(HEIGHT);
  localparam logic [c_xw:0]          c_one_x      = (c_xw+1)'(1);
  localparam logic [c_yw:0]          c_one_y      = (c_yw+1)'(1);
  localparam logic [c_xw-1:0]        c_start_x    = c_xw'(START_X);
  localparam logic [c_yw-1:0]        c_start_y    = c_yw'(START_Y);
  localparam logic [c_lw-1:0]        c_max_len    = c_lw'(MAX_LEN);
  localparam logic [BIT_DEPTH-1:0]   c_empty      = BIT_DEPTH'(CELL_EMPTY);
  localparam logic [BIT_DEPTH-1:0]   c_snake      = BIT_DEPTH'(CELL_SNAKE);
  localparam logic [BIT_DEPTH-1:0]   c_food       = BIT_DEPTH'(CELL_FOOD);
  localparam logic [BIT_DEPTH-1:0]   c_wall       = BIT_DEPTH'(CELL_WALL);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_READ, S_CHECK, S_HEAD, S_TAIL, S_DEAD
  } state_t;

  state_t             r_state, w_next;
  logic [c_xw-1:0]    r_hx, r_nx, r_tx, w_new_x;
  logic [c_yw-1:0]    r_hy, r_ny, r_ty, w_new_y;
  logic [c_xw:0]      w_ext_x;
  logic [c_yw:0]      w_ext_y;
  logic [1:0]         r_cur_dir, w_dir;
  logic               w_off, w_accept, w_hit, w_food;
  logic [c_xw-1:0]    r_ring_x [MAX_LEN];
  logic [c_yw-1:0]    r_ring_y [MAX_LEN];
  logic [c_pw-1:0]    r_head_ptr, r_tail_ptr;
  logic [c_lw-1:0]    r_length;
  logic               r_dead, r_ate, r_skip_tail, w_we;

  assign w_accept = (r_state == S_IDLE) && step && !r_dead;
  assign w_hit    = (area_rdata == c_snake) || (area_rdata == c_wall);
  assign w_food   = (area_rdata == c_food);

  // Candidate head, computed one bit wider so that both -1 and WIDTH/HEIGHT
  // show up as values >= the extent in a single unsigned compare.
  always_comb begin
    w_dir   = (dir == (r_cur_dir ^ 2'd2)) ? r_cur_dir : dir;
    w_ext_x = {1'b0, r_hx};
    w_ext_y = {1'b0, r_hy};
    case (w_dir)
      2'd0:    w_ext_y = w_ext_y - c_one_y;
      2'd1:    w_ext_x = w_ext_x + c_one_x;
      2'd2:    w_ext_y = w_ext_y + c_one_y;
      default: w_ext_x = w_ext_x - c_one_x;
    endcase
`ifdef SNAKE_WRAP_EN
    w_off = 1'b0;
    // MSB set means the coordinate went negative.
    if (w_ext_x >= c_width_ext)  w_ext_x = w_ext_x[c_xw] ? (c_width_ext - c_one_x) : '0;
    if (w_ext_y >= c_height_ext) w_ext_y = w_ext_y[c_yw] ? (c_height_ext - c_one_y) : '0;
`else
    w_off = (w_ext_x >= c_width_ext) || (w_ext_y >= c_height_ext);
`endif
    w_new_x = w_ext_x[c_xw-1:0];
    w_new_y = w_ext_y[c_yw-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_we       = 1'b0;
    area_x     = r_hx;
    area_y     = r_hy;
    area_wdata = c_empty;
    busy       = 1'b1;
    case (r_state)
      S_INIT: begin
        w_we       = 1'b1;
        area_x     = c_start_x;
        area_y     = c_start_y;
        area_wdata = c_snake;
        w_next     = S_IDLE;
      end
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_next = w_off ? S_DEAD : S_READ;
      end
      S_READ: begin
        area_x = r_nx;
        area_y = r_ny;
        w_next = S_CHECK;
      end
      S_CHECK: begin
        area_x = r_nx;
        area_y = r_ny;
        w_next = w_hit ? S_DEAD : S_HEAD;
      end
      S_HEAD: begin
        w_we       = 1'b1;
        area_x     = r_nx;
        area_y     = r_ny;
        area_wdata = c_snake;
        w_next     = r_skip_tail ? S_IDLE : S_TAIL;
      end
      S_TAIL: begin
        w_we       = 1'b1;
        area_x     = r_tx;
        area_y     = r_ty;
        area_wdata = c_empty;
        w_next     = S_IDLE;
      end
      S_DEAD:  busy   = 1'b0;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dead       <= 1'b0;
      r_ate        <= 1'b0;
      r_skip_tail  <= 1'b0;
      r_length     <= c_lw'(1);
      r_cur_dir    <= 2'd1;
      r_head_ptr   <= '0;
      r_tail_ptr   <= '0;
      r_hx         <= c_start_x;
      r_hy         <= c_start_y;
      r_nx         <= '0;
      r_ny         <= '0;
      r_tx         <= '0;
      r_ty         <= '0;
      r_ring_x[0]  <= c_start_x;
      r_ring_y[0]  <= c_start_y;
    end else begin
      r_ate <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cur_dir <= w_dir;
            r_nx      <= w_new_x;
            r_ny      <= w_new_y;
            if (w_off) r_dead <= 1'b1;
          end
        end
        S_CHECK: begin
          // Tail is latched here: when the ring is full the HEAD push lands
          // on the tail slot, so it cannot be read later.
          r_tx        <= r_ring_x[r_tail_ptr];
          r_ty        <= r_ring_y[r_tail_ptr];
          r_skip_tail <= w_food && (r_length != c_max_len);
          if (w_hit) begin
            r_dead <= 1'b1;
          end else if (w_food) begin
            r_ate <= 1'b1;
            if (r_length != c_max_len) r_length <= r_length + c_lw'(1);
          end
        end
        S_HEAD: begin
          r_hx                              <= r_nx;
          r_hy                              <= r_ny;
          r_head_ptr                        <= r_head_ptr + c_pw'(1);
          r_ring_x[r_head_ptr + c_pw'(1)]   <= r_nx;
          r_ring_y[r_head_ptr + c_pw'(1)]   <= r_ny;
        end
        S_TAIL:  r_tail_ptr <= r_tail_ptr + c_pw'(1);
        default: ;
      endcase
    end
  end

  // A write enable left over from a mid-move state must not reach the RAM
  // while reset is being applied.
  assign area_we = w_we & ~reset;
  assign dead    = r_dead;
  assign length  = r_length;
  assign ate     = r_ate;

endmodule
`default_nettype wire

// File: tb/tb_snake_mover.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_snake_mover                                                  |
// | Purpose  : Scoreboard bench for snake_mover. A grid/queue reference model  |
// |            predicts RAM writes (queued), busy duration, length, dead and   |
// |            food count; a monitor process pops and compares RAM writes.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_snake_mover;

  localparam int W = 80;
  localparam int H = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b0;
  logic [1:0] dir = 2'd1;
  logic [6:0] area_x;
  logic [5:0] area_y;
  logic       area_we;
  logic [2:0] area_wdata;
  logic [2:0] area_rdata = 3'd0;
  logic       busy, dead, ate;
  logic [6:0] length;

  snake_mover dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .dir        (dir),
    .area_x     (area_x),
    .area_y     (area_y),
    .area_we    (area_we),
    .area_wdata (area_wdata),
    .area_rdata (area_rdata),
    .busy       (busy),
    .dead       (dead),
    .length     (length),
    .ate        (ate)
  );

  always #5 clk = ~clk;

  // Play-area RAM with registered read and a bench-side load/clear port.
  logic [2:0] ram [0:W-1][0:H-1];
  logic       clr = 1'b0, ld_en = 1'b0;
  int         ld_x = 0, ld_y = 0;
  logic [2:0] ld_d = 3'd0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < W; i++)
        for (int j = 0; j < H; j++) ram[i][j] <= 3'd0;
    end else if (ld_en) begin
      ram[ld_x][ld_y] <= ld_d;
    end else if (area_we && area_x < W && area_y < H) begin
      ram[area_x][area_y] <= area_wdata;
    end
    area_rdata <= (area_x < W && area_y < H) ? ram[area_x][area_y] : 3'd0;
  end

  // Reference model state
  typedef struct { int x; int y; int d; } wr_t;
  wr_t exp_q[$];
  int  ref_grid [W][H];
  int  snake_x[$], snake_y[$];
  int  m_len, m_dir, m_dead, m_ate_exp;
  int  ate_total = 0, ate_base = 0;
  int  checks = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the oldest predicted write; ate must
  // coincide with a head write.
  always @(negedge clk) begin
    if (!reset && area_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL ram_write actual=(%0d,%0d,%0d) required=none", area_x, area_y, area_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (area_x != e.x || area_y != e.y || area_wdata != e.d) begin
          fails++;
          $display("FAIL ram_write actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                   area_x, area_y, area_wdata, e.x, e.y, e.d);
        end
      end
    end
    if (!reset && ate) begin
      ate_total++;
      checks++;
      if (!(area_we && area_wdata == 3'd1)) begin
        fails++;
        $display("FAIL ate_with_head_write actual=we%0d/d%0d required=we1/d1", area_we, area_wdata);
      end
    end
  end

  // One move by the rules: returns the expected number of busy cycles.
  task automatic model_step(input int d_in, output int exp_busy);
    int d, nx, ny, c, tx, ty;
    bit off;
    exp_busy = 0;
    if (m_dead) return;
    d = (d_in == (m_dir + 2) % 4) ? m_dir : d_in;
    m_dir = d;
    nx = snake_x[0] + (d == 1 ? 1 : 0) - (d == 3 ? 1 : 0);
    ny = snake_y[0] + (d == 2 ? 1 : 0) - (d == 0 ? 1 : 0);
    off = (nx < 0 || nx >= W || ny < 0 || ny >= H);
`ifdef SNAKE_WRAP_EN
    nx  = (nx + W) % W;
    ny  = (ny + H) % H;
    off = 1'b0;
`endif
    if (off) begin
      m_dead = 1;
      return;
    end
    c = ref_grid[nx][ny];
    if (c == 1 || c == 3) begin
      m_dead = 1;
      exp_busy = 2;
      return;
    end
    exp_q.push_back('{x: nx, y: ny, d: 1});
    ref_grid[nx][ny] = 1;
    snake_x.push_front(nx);
    snake_y.push_front(ny);
    if (c == 2) begin
      m_ate_exp++;
      if (m_len < 64) begin
        m_len++;
        exp_busy = 3;
        return;
      end
    end
    tx = snake_x.pop_back();
    ty = snake_y.pop_back();
    ref_grid[tx][ty] = 0;
    exp_q.push_back('{x: tx, y: ty, d: 0});
    exp_busy = 4;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1; clr = 1'b1; step = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++) ref_grid[i][j] = 0;
    snake_x.delete(); snake_y.delete();
    snake_x.push_back(40); snake_y.push_back(30);
    ref_grid[40][30] = 1;
    m_len = 1; m_dir = 1; m_dead = 0; m_ate_exp = 0;
    ate_base = ate_total;
    exp_q.delete();
    exp_q.push_back('{x: 40, y: 30, d: 1});
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_length", length, 1);
    chk("reset_dead", dead, 0);
    chk("reset_ate", ate, 0);
    chk("reset_init_write_pending", exp_q.size(), 0);
  endtask

  task automatic load_cell(input int x, input int y, input int v);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_x = x; ld_y = y; ld_d = 3'(v);
    @(posedge clk); #1;
    ld_en = 1'b0;
    ref_grid[x][y] = v;
  endtask

  task automatic do_step(input int d, input bit extra);
    int eb, n;
    model_step(d, eb);
    @(posedge clk); #1;
    dir = 2'(d); step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    n = 0;
    while (busy && n < 12) begin
      step = (extra && n == 1);
      @(posedge clk); #1;
      n++;
    end
    step = 1'b0;
    chk("busy_cycles", n, eb);
    chk("length", length, m_len);
    chk("dead", dead, m_dead);
    chk("ate_count", ate_total - ate_base, m_ate_exp);
    chk("pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);

    // Directed: plain move, food, opposite-direction request, wall.
    reset_dut();
    do_step(1, 0);
    load_cell(42, 30, 2);
    do_step(1, 0);
    do_step(3, 1);
    do_step(2, 0);
    load_cell(43, 32, 3);
    do_step(2, 0);
    do_step(1, 0);
    do_step(0, 0);

    // Edges: right edge and top edge.
    reset_dut();
    for (int s = 0; s < 40; s++) do_step(1, 0);
    reset_dut();
    for (int s = 0; s < 31; s++) do_step(0, 0);

    // Growth up to and past the maximum length.
    reset_dut();
    for (int x = 41; x < W; x++) load_cell(x, 30, 2);
    for (int x = 49; x < W; x++) load_cell(x, 31, 2);
    for (int s = 0; s < 39; s++) do_step(1, 0);
    do_step(2, 0);
    for (int s = 0; s < 30; s++) do_step(3, 0);

    // Randomized fields and directions.
    for (int r = 0; r < 4; r++) begin
      reset_dut();
      for (int k = 0; k < 120; k++) begin
        int x, y;
        x = $urandom_range(0, W-1);
        y = $urandom_range(0, H-1);
        if (!(x == 40 && y == 30))
          load_cell(x, y, ($urandom_range(0, 3) == 0) ? 3 : 2);
      end
      for (int s = 0; s < 80 && !m_dead; s++)
        do_step($urandom_range(0, 3), $urandom_range(0, 3) == 0);
      do_step($urandom_range(0, 3), 1'b0);
    end

    reset_dut();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
